// File: rtl/alu_share_arb.sv
// Two-port front end for a single RV32I ALU: round-robin arbitration, one issue per
// cycle, and a one-entry registered response slot per requester.
module alu_share_arb #(
  parameter int N_BITS   = 32,
  parameter int TAG_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0][3:0]          req_op_i,
  input  logic [1:0][N_BITS-1:0]   req_a_i,
  input  logic [1:0][N_BITS-1:0]   req_b_i,
  input  logic [1:0][TAG_BITS-1:0] req_tag_i,
  output logic [1:0]               rsp_valid_o,
  input  logic [1:0]               rsp_ready_i,
  output logic [1:0][N_BITS-1:0]   rsp_data_o,
  output logic [1:0][TAG_BITS-1:0] rsp_tag_o,
  output logic [1:0]               rsp_err_o,
  output logic                     busy_o,
  output logic                     dbg_rr_ptr_o,
  output logic [1:0]               dbg_slot_full_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready. Requesters hold
  // valid and payload stable until ready; responses stay stable while valid && !ready.

  localparam int SHW = $clog2(N_BITS);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  slot_e                slot_q [2];
  slot_e                slot_d [2];
  logic [N_BITS-1:0]    data_q [2];
  logic [N_BITS-1:0]    data_d [2];
  logic [TAG_BITS-1:0]  tag_q  [2];
  logic [TAG_BITS-1:0]  tag_d  [2];
  logic [1:0]           err_q;
  logic [1:0]           err_d;
  logic                 rr_q;
  logic                 rr_d;

  logic [1:0]           elig;
  logic [1:0]           grant;
  logic                 win;
  logic [3:0]           op;
  logic [N_BITS-1:0]    op_a;
  logic [N_BITS-1:0]    op_b;
  logic [SHW-1:0]       shamt;
  logic [N_BITS-1:0]    alu_res;
  logic                 alu_err;

  // A full slot can accept a new result only if it is draining this same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      elig[p] = req_valid_i[p] && ((slot_q[p] == SLOT_EMPTY) || rsp_ready_i[p]);
    end
    grant = elig;
    if (&elig) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end
  end

  assign win   = grant[1];
  assign op    = req_op_i[win];
  assign op_a  = req_a_i[win];
  assign op_b  = req_b_i[win];
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a << shamt;
      4'b0100: alu_res = {{(N_BITS-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0110: alu_res = {{(N_BITS-1){1'b0}}, (op_a < op_b)};
      4'b1000: alu_res = op_a ^ op_b;
      4'b1010: alu_res = op_a >> shamt;
      4'b1011: alu_res = $unsigned($signed(op_a) >>> shamt);
      4'b1100: alu_res = op_a | op_b;
      4'b1110: alu_res = op_a & op_b;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      slot_d[p] = slot_q[p];
      data_d[p] = data_q[p];
      tag_d[p]  = tag_q[p];
      err_d[p]  = err_q[p];
      if (grant[p]) begin
        slot_d[p] = SLOT_FULL;
        data_d[p] = alu_res;
        tag_d[p]  = req_tag_i[p];
        err_d[p]  = alu_err;
      end else if ((slot_q[p] == SLOT_FULL) && rsp_ready_i[p]) begin
        slot_d[p] = SLOT_EMPTY;
      end
    end
    rr_d = (|grant) ? ~win : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        slot_q[p] <= SLOT_EMPTY;
        data_q[p] <= '0;
        tag_q[p]  <= '0;
      end
      err_q <= '0;
      rr_q  <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        slot_q[p] <= slot_d[p];
        data_q[p] <= data_d[p];
        tag_q[p]  <= tag_d[p];
      end
      err_q <= err_d;
      rr_q  <= rr_d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rsp_valid_o[p]     = (slot_q[p] == SLOT_FULL);
      dbg_slot_full_o[p] = (slot_q[p] == SLOT_FULL);
      rsp_data_o[p]      = data_q[p];
      rsp_tag_o[p]       = tag_q[p];
    end
  end

  assign rsp_err_o    = err_q;
  assign req_ready_o  = grant;
  assign busy_o       = (|rsp_valid_o) || (|req_valid_i);
  assign dbg_rr_ptr_o = rr_q;

endmodule
